fb_swap_scheduler: RTL and testbench

Sequences the double-buffered colour/Z framebuffer used by the triangle pipeline. Owns the single back-buffer write port and shares it between an internal clear engine and the rasterizer's pixel writes. Swaps front/back buffers only on a vsync falling edge, and only after the pipeline reports its frame complete. Sits between the rasterizer/Z-test output and the framebuffer and Z-buffer BRAM write ports, in the pixel_clk domain.

---
 rtl/fb_sched_pkg.sv | 14 +
 rtl/fb_clear_seq.sv | 31 +++
 rtl/fb_swap_scheduler.sv | 130 +++++++++++++
 tb/tb_fb_swap_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the framebuffer swap scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {StClear, StDraw, StWaitVs} sched_state_e;

  localparam logic [7:0]  DefClearColor = 8'h00;
  localparam logic [15:0] DefClearZ     = 16'hFFFF;

  // Number of pixels in one buffer.
  function automatic int unsigned fb_depth(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Clear engine address counter: walks every pixel of the back buffer once per clear.
module fb_clear_seq
  import fb_sched_pkg::*;
#(
  parameter int unsigned Depth  = 76800,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              pixel_clk,
  input  logic              arstn,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  logic [ADDR_W-1:0] addr_q;

  assign addr = addr_q;
  assign last = (addr_q == LastAddr);

  // Advance while running; wrap after the last pixel so the next clear starts at 0.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      addr_q <= '0;
    end else if (run) begin
      addr_q <= last ? '0 : addr_q + 1'b1;
    end
  end

endmodule

// File: rtl/fb_swap_scheduler.sv
// Double-buffer sequencer: owns the back-buffer write port, arbitrates clear vs rasterizer
// writes, and swaps buffers on the first vsync fall after the frame is complete.
module fb_swap_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned         FB_W        = 320,
  parameter int unsigned         FB_H        = 240,
  parameter int unsigned         ADDR_W      = 17,
  parameter int unsigned         COLOR_W     = 8,
  parameter int unsigned         Z_W         = 16,
  parameter logic [COLOR_W-1:0]  CLEAR_COLOR = COLOR_W'(DefClearColor),
  parameter logic [Z_W-1:0]      CLEAR_Z     = Z_W'(DefClearZ)
) (
  input  logic               pixel_clk,
  input  logic               arstn,
  input  logic               vsync,
  input  logic               frame_done,
  input  logic               draw_we,
  input  logic [ADDR_W-1:0]  draw_addr,
  input  logic [COLOR_W-1:0] draw_color,
  input  logic [Z_W-1:0]     draw_z,
  output logic               draw_grant,
  output logic               front_sel,
  output logic               fb_we,
  output logic               zb_we,
  output logic               wr_buf,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_color,
  output logic [Z_W-1:0]     wr_z,
  output logic               busy_clear,
  output logic [15:0]        swap_count,
  output logic               err_drop
);

  localparam int unsigned FbDepth = fb_depth(FB_W, FB_H);

  sched_state_e      state_q;
  logic              done_pending_q;
  logic              vs_d_q;
  logic              clear_run;
  logic              clear_last;
  logic              vs_fall;
  logic [ADDR_W-1:0] clear_addr;

  assign clear_run = (state_q == StClear);
  assign vs_fall   = vs_d_q & ~vsync;

  fb_clear_seq #(
    .Depth  (FbDepth),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .run       (clear_run),
    .addr      (clear_addr),
    .last      (clear_last)
  );

  // State machine and registered write port; draw_grant is high exactly while in StDraw.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state_q        <= StClear;
      done_pending_q <= 1'b0;
      vs_d_q         <= 1'b1;
      front_sel      <= 1'b0;
      wr_buf         <= 1'b1;
      draw_grant     <= 1'b0;
      fb_we          <= 1'b0;
      zb_we          <= 1'b0;
      wr_addr        <= '0;
      wr_color       <= '0;
      wr_z           <= '0;
      busy_clear     <= 1'b0;
      swap_count     <= '0;
      err_drop       <= 1'b0;
    end else begin
      vs_d_q     <= vsync;
      fb_we      <= 1'b0;
      zb_we      <= 1'b0;
      busy_clear <= 1'b0;
      if (draw_we && !draw_grant) begin
        err_drop <= 1'b1;
      end
      unique case (state_q)
        StClear: begin
          fb_we      <= 1'b1;
          zb_we      <= 1'b1;
          busy_clear <= 1'b1;
          wr_addr    <= clear_addr;
          wr_color   <= CLEAR_COLOR;
          wr_z       <= CLEAR_Z;
          if (frame_done) begin
            done_pending_q <= 1'b1;
          end
          if (clear_last) begin
            state_q    <= StDraw;
            draw_grant <= 1'b1;
          end
        end
        StDraw: begin
          if (draw_we) begin
            fb_we    <= 1'b1;
            zb_we    <= 1'b1;
            wr_addr  <= draw_addr;
            wr_color <= draw_color;
            wr_z     <= draw_z;
          end
          if (frame_done || done_pending_q) begin
            done_pending_q <= 1'b0;
            draw_grant     <= 1'b0;
            state_q        <= StWaitVs;
          end
        end
        StWaitVs: begin
          if (frame_done) begin
            done_pending_q <= 1'b1;
          end
          if (vs_fall) begin
            front_sel  <= ~front_sel;
            wr_buf     <= front_sel;
            swap_count <= swap_count + 16'd1;
            state_q    <= StClear;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Bench: full-size instance checks the first clear and a forwarded write; a small-geometry
// instance runs randomized traffic against a behavioural model.
module tb_fb_swap_scheduler;

  localparam int unsigned FullDepth = 320 * 240;
  localparam int unsigned SW = 8, SH = 6, SA = 6;
  localparam int unsigned SmallDepth = SW * SH;
  localparam int unsigned RandCycles = 12000;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Full-size instance
  logic        f_arstn, f_vsync, f_frame_done, f_draw_we;
  logic [16:0] f_draw_addr;
  logic [7:0]  f_draw_color;
  logic [15:0] f_draw_z;
  logic        f_grant, f_front, f_fb_we, f_zb_we, f_wr_buf, f_busy, f_err;
  logic [16:0] f_wr_addr;
  logic [7:0]  f_wr_color;
  logic [15:0] f_wr_z, f_swaps;

  fb_swap_scheduler dut_full (
    .pixel_clk  (pixel_clk),
    .arstn      (f_arstn),
    .vsync      (f_vsync),
    .frame_done (f_frame_done),
    .draw_we    (f_draw_we),
    .draw_addr  (f_draw_addr),
    .draw_color (f_draw_color),
    .draw_z     (f_draw_z),
    .draw_grant (f_grant),
    .front_sel  (f_front),
    .fb_we      (f_fb_we),
    .zb_we      (f_zb_we),
    .wr_buf     (f_wr_buf),
    .wr_addr    (f_wr_addr),
    .wr_color   (f_wr_color),
    .wr_z       (f_wr_z),
    .busy_clear (f_busy),
    .swap_count (f_swaps),
    .err_drop   (f_err)
  );

  // Small instance
  logic          s_arstn, s_vsync, s_frame_done, s_draw_we;
  logic [SA-1:0] s_draw_addr;
  logic [7:0]    s_draw_color;
  logic [15:0]   s_draw_z;
  logic          s_grant, s_front, s_fb_we, s_zb_we, s_wr_buf, s_busy, s_err;
  logic [SA-1:0] s_wr_addr;
  logic [7:0]    s_wr_color;
  logic [15:0]   s_wr_z, s_swaps;

  fb_swap_scheduler #(
    .FB_W   (SW),
    .FB_H   (SH),
    .ADDR_W (SA)
  ) dut_small (
    .pixel_clk  (pixel_clk),
    .arstn      (s_arstn),
    .vsync      (s_vsync),
    .frame_done (s_frame_done),
    .draw_we    (s_draw_we),
    .draw_addr  (s_draw_addr),
    .draw_color (s_draw_color),
    .draw_z     (s_draw_z),
    .draw_grant (s_grant),
    .front_sel  (s_front),
    .fb_we      (s_fb_we),
    .zb_we      (s_zb_we),
    .wr_buf     (s_wr_buf),
    .wr_addr    (s_wr_addr),
    .wr_color   (s_wr_color),
    .wr_z       (s_wr_z),
    .busy_clear (s_busy),
    .swap_count (s_swaps),
    .err_drop   (s_err)
  );

  // Behavioural model: pixels left to clear, drawing/waiting phase, sticky flags.
  int          m_clear_left;
  bit          m_drawing, m_pend, m_vsd, m_front, m_err;
  bit          m_we, m_grant, m_busy;
  int          m_swaps;
  logic [SA-1:0] m_addr;
  logic [7:0]  m_color;
  logic [15:0] m_z;

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit fall;
    if (!s_arstn) begin
      m_clear_left = SmallDepth;
      m_drawing = 0; m_pend = 0; m_vsd = 1; m_front = 0; m_err = 0;
      m_we = 0; m_grant = 0; m_busy = 0; m_swaps = 0;
      m_addr = '0; m_color = '0; m_z = '0;
    end else begin
      fall  = m_vsd && !s_vsync;
      m_vsd = s_vsync;
      m_we   = 0;
      m_busy = 0;
      if (m_clear_left > 0) begin
        m_we    = 1;
        m_busy  = 1;
        m_addr  = SA'(SmallDepth - m_clear_left);
        m_color = 8'h00;
        m_z     = 16'hFFFF;
        m_clear_left--;
        if (s_frame_done) m_pend = 1;
        if (s_draw_we) m_err = 1;
        if (m_clear_left == 0) begin
          m_drawing = 1;
          m_grant   = 1;
        end
      end else if (m_drawing) begin
        if (s_draw_we) begin
          m_we    = 1;
          m_addr  = s_draw_addr;
          m_color = s_draw_color;
          m_z     = s_draw_z;
        end
        if (s_frame_done || m_pend) begin
          m_pend    = 0;
          m_drawing = 0;
          m_grant   = 0;
        end
      end else begin
        if (s_draw_we) m_err = 1;
        if (s_frame_done) m_pend = 1;
        if (fall) begin
          m_front      = !m_front;
          m_swaps      = (m_swaps + 1) % 65536;
          m_clear_left = SmallDepth;
        end
      end
    end
  endtask

  task automatic compare_small();
    check("s_fb_we", 32'(s_fb_we), 32'(m_we));
    check("s_zb_we", 32'(s_zb_we), 32'(m_we));
    check("s_grant", 32'(s_grant), 32'(m_grant));
    check("s_busy", 32'(s_busy), 32'(m_busy));
    check("s_front", 32'(s_front), 32'(m_front));
    check("s_wr_buf", 32'(s_wr_buf), 32'(!m_front));
    check("s_swaps", 32'(s_swaps), 32'(m_swaps));
    check("s_err", 32'(s_err), 32'(m_err));
    if (m_we) begin
      check("s_wr_addr", 32'(s_wr_addr), 32'(m_addr));
      check("s_wr_color", 32'(s_wr_color), 32'(m_color));
      check("s_wr_z", 32'(s_wr_z), 32'(m_z));
    end
  endtask

  initial begin
    int vs_cnt;
    f_arstn = 0; f_vsync = 1; f_frame_done = 0; f_draw_we = 0;
    f_draw_addr = '0; f_draw_color = '0; f_draw_z = '0;
    s_arstn = 0; s_vsync = 1; s_frame_done = 0; s_draw_we = 0;
    s_draw_addr = '0; s_draw_color = '0; s_draw_z = '0;

    // Full-size reset state
    repeat (2) @(posedge pixel_clk);
    #1;
    check("f_rst_busy", 32'(f_busy), 32'd0);
    check("f_rst_grant", 32'(f_grant), 32'd0);
    check("f_rst_fb_we", 32'(f_fb_we), 32'd0);
    check("f_rst_front", 32'(f_front), 32'd0);
    check("f_rst_wr_buf", 32'(f_wr_buf), 32'd1);
    check("f_rst_swaps", 32'(f_swaps), 32'd0);
    check("f_rst_err", 32'(f_err), 32'd0);
    f_arstn = 1;

    // Full-size clear: one write per pixel, in address order, into buffer 1
    for (int i = 0; i < int'(FullDepth); i++) begin
      @(posedge pixel_clk);
      #1;
      check("f_clr_busy", 32'(f_busy), 32'd1);
      check("f_clr_fb_we", 32'(f_fb_we & f_zb_we), 32'd1);
      check("f_clr_addr", 32'(f_wr_addr), 32'(i));
      check("f_clr_color", 32'(f_wr_color), 32'h00);
      check("f_clr_z", 32'(f_wr_z), 32'hFFFF);
      check("f_clr_wr_buf", 32'(f_wr_buf), 32'd1);
      if (i == int'(FullDepth) - 1) check("f_grant_at_draw", 32'(f_grant), 32'd1);
    end
    @(posedge pixel_clk);
    #1;
    check("f_post_busy", 32'(f_busy), 32'd0);
    check("f_post_grant", 32'(f_grant), 32'd1);
    check("f_post_front", 32'(f_front), 32'd0);
    check("f_post_fb_we", 32'(f_fb_we), 32'd0);

    // Forwarded rasterizer write with one cycle of latency
    f_draw_we = 1; f_draw_addr = 17'd12345; f_draw_color = 8'hE0; f_draw_z = 16'd50;
    @(posedge pixel_clk);
    #1;
    f_draw_we = 0;
    check("f_drw_fb_we", 32'(f_fb_we), 32'd1);
    check("f_drw_zb_we", 32'(f_zb_we), 32'd1);
    check("f_drw_addr", 32'(f_wr_addr), 32'd12345);
    check("f_drw_color", 32'(f_wr_color), 32'hE0);
    check("f_drw_z", 32'(f_wr_z), 32'd50);
    check("f_drw_wr_buf", 32'(f_wr_buf), 32'd1);
    check("f_drw_err", 32'(f_err), 32'd0);

    // Small instance: randomized traffic against the model
    vs_cnt = 100;
    for (int c = 0; c < int'(RandCycles); c++) begin
      @(posedge pixel_clk);
      model_edge();
      #1;
      compare_small();
      s_arstn      = (c < 2) ? 1'b0 : (($urandom % 4000) != 0);
      s_frame_done = (($urandom % 50) == 0);
      s_draw_we    = $urandom % 2;
      s_draw_addr  = SA'($urandom % SmallDepth);
      s_draw_color = 8'($urandom);
      s_draw_z     = 16'($urandom);
      if (vs_cnt == 0) vs_cnt = $urandom_range(60, 200);
      s_vsync = (vs_cnt > 3);
      vs_cnt--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
